// File: rtl/fpa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpa_pkg
// Brief   : Shared types and constants for the FP32 add operand stage.
//           Operand classes, unpacked operand record and ordered pair record.
// Revision: 1.0  initial release
// ============================================================================
package fpa_pkg;

   localparam logic [7:0] EXP_MAX = 8'hFF;
   localparam int         BIAS    = 127;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_NAN  = 3'd4
   } fpa_cls_t;

   // One operand after unpacking: effective exponent and {hidden, fraction}
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] mant;
      fpa_cls_t    cls;
   } fpa_unpacked_t;

   // Magnitude-ordered operand pair as handed to the add core
   typedef struct packed {
      fpa_unpacked_t big;
      fpa_unpacked_t sml;
      logic [7:0]    exp_diff;
      logic          swapped;
   } fpa_pair_t;

endpackage
`default_nettype wire

// File: rtl/fpa_classify.sv
`default_nettype none
// ============================================================================
// Module  : fpa_classify
// Brief   : Combinational classifier/unpacker for one IEEE-754 binary32 value.
//           Subnormals get effective exponent 1 and hidden bit 0.
//           Define FPA_DAZ_EN to flush subnormal inputs to signed zero.
// Revision: 1.0  initial release
// ============================================================================
module fpa_classify
   import fpa_pkg::*;
(
   input  logic [31:0]   number_i,
   output fpa_unpacked_t unp_o
);

   logic [7:0]  w_exp;
   logic [22:0] w_frac;

   assign w_exp  = number_i[30:23];
   assign w_frac = number_i[22:0];

   // Decode exponent/fraction into class and effective exponent/mantissa
   always_comb begin
      unp_o.sign = number_i[31];
      unp_o.exp  = w_exp;
      unp_o.mant = {1'b1, w_frac};
      unp_o.cls  = CLS_NORM;
      if (w_exp == 8'd0) begin
         unp_o.exp  = 8'd0;
         unp_o.mant = 24'd0;
         unp_o.cls  = CLS_ZERO;
`ifdef FPA_DAZ_EN
         // Subnormals are treated exactly like zero; sign survives.
`else
         if (w_frac != 23'd0) begin
            unp_o.exp  = 8'd1;
            unp_o.mant = {1'b0, w_frac};
            unp_o.cls  = CLS_SUB;
         end
`endif
      end else if (w_exp == EXP_MAX) begin
         unp_o.cls = (w_frac == 23'd0) ? CLS_INF : CLS_NAN;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpa_operand_unpack.sv
`default_nettype none
// ============================================================================
// Module  : fpa_operand_unpack
// Brief   : Operand stage for the FP32 add core. Classifies and unpacks both
//           operands, orders them by magnitude, precomputes the exponent
//           difference and counts NaN-carrying pairs. One output register
//           plus a one-entry skid buffer keep in_ready registered at full
//           throughput. Optional macro: FPA_DAZ_EN (flush subnormals).
// Revision: 1.0  initial release
// ============================================================================
module fpa_operand_unpack
   import fpa_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      number_A,
   input  logic [31:0]      number_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             big_sign,
   output logic [7:0]       big_exp,
   output logic [23:0]      big_mant,
   output logic [2:0]       big_cls,
   output logic             sml_sign,
   output logic [7:0]       sml_exp,
   output logic [23:0]      sml_mant,
   output logic [2:0]       sml_cls,
   output logic [7:0]       exp_diff,
   output logic             swapped,
   output logic [CNT_W-1:0] nan_cnt
);

   fpa_unpacked_t    unp_a, unp_b;
   logic [30:0]      mag_a, mag_b;
   logic             swap;
   fpa_pair_t        pair_new;
   logic             accept;
   logic             has_nan;

   fpa_pair_t        out_q, out_d;
   fpa_pair_t        skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

   fpa_classify u_cls_a (.number_i(number_A), .unp_o(unp_a));
   fpa_classify u_cls_b (.number_i(number_B), .unp_o(unp_b));

   // Order the pair by magnitude of the (possibly flushed) values; ties keep A big
   always_comb begin
      mag_a = (unp_a.cls == CLS_ZERO) ? 31'd0 : number_A[30:0];
      mag_b = (unp_b.cls == CLS_ZERO) ? 31'd0 : number_B[30:0];
      swap  = (mag_b > mag_a);
      pair_new.big      = swap ? unp_b : unp_a;
      pair_new.sml      = swap ? unp_a : unp_b;
      pair_new.exp_diff = pair_new.big.exp - pair_new.sml.exp;
      pair_new.swapped  = swap;
   end

   assign accept  = in_valid & in_ready_q;
   assign has_nan = (unp_a.cls == CLS_NAN) | (unp_b.cls == CLS_NAN);

   // Output register / skid buffer next state; skid only fills while output stalls
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (accept) begin
         if (!out_valid_q || out_ready) begin
            out_d       = pair_new;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = pair_new;
            skid_valid_d = 1'b1;
         end
      end else if (skid_valid_q && out_ready) begin
         out_d        = skid_q;
         out_valid_d  = 1'b1;
         skid_valid_d = 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      in_ready_d = ~skid_valid_d;
   end

   // Saturating count of accepted pairs carrying at least one NaN
   always_comb begin
      nan_cnt_d = nan_cnt_q;
      if (accept && has_nan && (nan_cnt_q != {CNT_W{1'b1}})) begin
         nan_cnt_d = nan_cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset clears all contents and holds in_ready low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         nan_cnt_q    <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         nan_cnt_q    <= nan_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign big_sign  = out_q.big.sign;
   assign big_exp   = out_q.big.exp;
   assign big_mant  = out_q.big.mant;
   assign big_cls   = out_q.big.cls;
   assign sml_sign  = out_q.sml.sign;
   assign sml_exp   = out_q.sml.exp;
   assign sml_mant  = out_q.sml.mant;
   assign sml_cls   = out_q.sml.cls;
   assign exp_diff  = out_q.exp_diff;
   assign swapped   = out_q.swapped;
   assign nan_cnt   = nan_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fpa_operand_unpack.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpa_operand_unpack
// Brief   : Self-checking bench for fpa_operand_unpack (and a CNT_W=4 copy).
// Revision: 1.0  initial release
// ============================================================================
module tb_fpa_operand_unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] number_A, number_B;

   logic        in_ready, out_valid, big_sign, sml_sign, swapped;
   logic [7:0]  big_exp, sml_exp, exp_diff;
   logic [23:0] big_mant, sml_mant;
   logic [2:0]  big_cls, sml_cls;
   logic [15:0] nan_cnt;

   logic        d4_in_ready, d4_out_valid, d4_big_sign, d4_sml_sign, d4_swapped;
   logic [7:0]  d4_big_exp, d4_sml_exp, d4_exp_diff;
   logic [23:0] d4_big_mant, d4_sml_mant;
   logic [2:0]  d4_big_cls, d4_sml_cls;
   logic [3:0]  d4_nan_cnt;

   always #5 clk = ~clk;

   fpa_operand_unpack #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .number_A(number_A), .number_B(number_B),
      .out_valid(out_valid), .out_ready(out_ready),
      .big_sign(big_sign), .big_exp(big_exp), .big_mant(big_mant), .big_cls(big_cls),
      .sml_sign(sml_sign), .sml_exp(sml_exp), .sml_mant(sml_mant), .sml_cls(sml_cls),
      .exp_diff(exp_diff), .swapped(swapped), .nan_cnt(nan_cnt)
   );

   fpa_operand_unpack #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
      .number_A(number_A), .number_B(number_B),
      .out_valid(d4_out_valid), .out_ready(out_ready),
      .big_sign(d4_big_sign), .big_exp(d4_big_exp), .big_mant(d4_big_mant), .big_cls(d4_big_cls),
      .sml_sign(d4_sml_sign), .sml_exp(d4_sml_exp), .sml_mant(d4_sml_mant), .sml_cls(d4_sml_cls),
      .exp_diff(d4_exp_diff), .swapped(d4_swapped), .nan_cnt(d4_nan_cnt)
   );

   logic [80:0] dut_vec;
   assign dut_vec = {big_sign, big_exp, big_mant, big_cls,
                     sml_sign, sml_exp, sml_mant, sml_cls, exp_diff, swapped};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Operand record {sign, exp[7:0], mant[23:0], cls[2:0]} from IEEE-754 rules
   function automatic logic [35:0] tb_unpack(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] f;
      e = x[30:23];
      f = x[22:0];
      if (e == 8'd0 && f == 23'd0) return {x[31], 8'd0, 24'd0, 3'd0};
      if (e == 8'd0) begin
`ifdef FPA_DAZ_EN
         return {x[31], 8'd0, 24'd0, 3'd0};
`else
         return {x[31], 8'd1, 1'b0, f, 3'd1};
`endif
      end
      if (e == 8'hFF) return {x[31], e, 1'b1, f, (f == 23'd0) ? 3'd3 : 3'd4};
      return {x[31], e, 1'b1, f, 3'd2};
   endfunction

   function automatic logic [80:0] tb_pair(input logic [31:0] a, input logic [31:0] b);
      logic [35:0] ua, ub, bg, sm;
      logic [30:0] ma, mb;
      logic        sw;
      ua = tb_unpack(a);
      ub = tb_unpack(b);
      ma = (ua[2:0] == 3'd0) ? 31'd0 : a[30:0];
      mb = (ub[2:0] == 3'd0) ? 31'd0 : b[30:0];
      sw = (mb > ma);
      bg = sw ? ub : ua;
      sm = sw ? ua : ub;
      return {bg, sm, bg[34:27] - sm[34:27], sw};
   endfunction

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   logic [80:0] exp_q[$];
   int          nan_m  = 0;
   int          nan4_m = 0;
   logic        armed;

   always @(posedge clk or negedge rst) begin
      if (!rst) armed <= 1'b0;
      else      armed <= 1'b1;
   end

   // Compare process: every negedge, handshakes are stable until the next posedge
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         nan_m  = 0;
         nan4_m = 0;
      end else begin
         chk("in_ready", in_ready, armed && (exp_q.size() < 2));
         chk("out_valid", out_valid, exp_q.size() > 0);
         chk("nan_cnt", nan_cnt, nan_m);
         chk("nan_cnt4", d4_nan_cnt, nan4_m);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else chk("out_pair", dut_vec, exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(tb_pair(number_A, number_B));
            if (is_nan(number_A) || is_nan(number_B)) begin
               if (nan_m < 65535) nan_m++;
               if (nan4_m < 15) nan4_m++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] sa[20];
   logic [31:0] sb[20];
   int          pat[8];

   // Single pair into an idle stage; caller checks outputs on return
   task automatic send_lit(input logic [31:0] a, input logic [31:0] b);
      number_A  = a;
      number_B  = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic stream(input int n);
      int  sent;
      int  cyc;
      bit  acc;
      sent = 0;
      cyc  = 0;
      while (sent < n && cyc < 200) begin
         in_valid  = 1'b1;
         number_A  = sa[sent];
         number_B  = sb[sent];
         out_ready = (pat[cyc % 8] != 0);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      if (sent < n) chk("stream_timeout", sent, n);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      number_A  = '0;
      number_B  = '0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_nan_cnt", nan_cnt, 0);
      chk("rst_data", dut_vec, 0);
      #10 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst", in_ready, 1);

      // 1.0 vs 2.0
      send_lit(32'h3F800000, 32'h40000000);
      chk("lit_1p0_2p0", dut_vec,
          {1'b0, 8'd128, 24'h800000, 3'd2, 1'b0, 8'd127, 24'h800000, 3'd2, 8'd1, 1'b1});

      // smallest subnormal vs smallest normal
      send_lit(32'h00000001, 32'h00800000);
`ifdef FPA_DAZ_EN
      chk("lit_sub_norm", dut_vec,
          {1'b0, 8'd1, 24'h800000, 3'd2, 1'b0, 8'd0, 24'h000000, 3'd0, 8'd1, 1'b1});
`else
      chk("lit_sub_norm", dut_vec,
          {1'b0, 8'd1, 24'h800000, 3'd2, 1'b0, 8'd1, 24'h000001, 3'd1, 8'd0, 1'b1});
`endif

      // NaN vs -Inf
      send_lit(32'h7FC00000, 32'hFF800000);
      chk("lit_nan_inf", dut_vec,
          {1'b0, 8'hFF, 24'hC00000, 3'd4, 1'b1, 8'hFF, 24'h800000, 3'd3, 8'd0, 1'b0});
      chk("lit_nan_cnt1", nan_cnt, 1);

      // -0 vs -0
      send_lit(32'h80000000, 32'h80000000);
      chk("lit_negzero", dut_vec,
          {1'b1, 8'd0, 24'd0, 3'd0, 1'b1, 8'd0, 24'd0, 3'd0, 8'd0, 1'b0});

      // back-to-back stream under a stalling consumer
      sa[0] = 32'h40490FDB; sb[0] = 32'h3F800000;
      sa[1] = 32'h00400000; sb[1] = 32'h80000001;
      sa[2] = 32'hC2F60000; sb[2] = 32'h42F60000;
      sa[3] = 32'h7F800000; sb[3] = 32'h7F7FFFFF;
      sa[4] = 32'h00000000; sb[4] = 32'h807FFFFF;
      sa[5] = 32'h3F000000; sb[5] = 32'h7FC00001;
      sa[6] = 32'h7F7FFFFF; sb[6] = 32'h00000001;
      sa[7] = 32'h12345678; sb[7] = 32'h9ABCDEF0;
      pat = '{1, 0, 0, 1, 0, 1, 1, 1};
      stream(8);

      // reset while output and skid are both occupied
      out_ready = 1'b0;
      in_valid  = 1'b1;
      number_A  = 32'h7FC00000; number_B = 32'h00000001;
      @(posedge clk); #1;
      number_A  = 32'h40000000; number_B = 32'h7FFFFFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_nan_cnt", nan_cnt, 0);
      chk("mid_rst_data", dut_vec, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      send_lit(32'h3F800000, 32'h3F800000);
      chk("post_rst_pair", dut_vec,
          {1'b0, 8'd127, 24'h800000, 3'd2, 1'b0, 8'd127, 24'h800000, 3'd2, 8'd0, 1'b0});
      @(posedge clk); #1;
      chk("post_rst_empty", out_valid, 0);

      // counter saturation on the CNT_W=4 copy
      for (int i = 0; i < 20; i++) begin
         sa[i] = 32'h7FC00000 | i;
         sb[i] = 32'h3F800000 + i;
      end
      pat = '{1, 1, 1, 1, 1, 1, 1, 1};
      stream(20);
      chk("nan_cnt_20", nan_cnt, 20);
      chk("nan_cnt4_sat", d4_nan_cnt, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
